// File: rtl/ps2_host_ctrl.sv
// PS/2 host line controller: device-to-host receive and host-to-device command
// transmit over the shared open-drain clock/data pair, with framing checks.
module ps2_host_ctrl #(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned FILTER         = 8,
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_err
);

  localparam int unsigned FLT_W = $clog2(FILTER + 1);
  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1) + ((CLK_HZ == 0) ? 1 : 0);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_INHIBIT, S_REQ, S_TX, S_ACK, S_WAIT_IDLE
  } state_t;

  // Index 0 is the clock line, index 1 the data line.
  logic [1:0]       sync1_q, sync2_q, filt_q, flip_c;
  logic [FLT_W-1:0] fcnt_q [2];
  logic             clk_prev_q;

  state_t           state_q;
  logic [3:0]       bit_q;
  logic [8:0]       rx_sh_q;
  logic             start_q;
  logic [7:0]       tx_q;
  logic             par_q;
  logic [INH_W-1:0] inh_q;
  logic [TO_W-1:0]  to_q;
  logic             clk_oe_q, data_oe_q, tx_ready_q, tx_done_q, tx_err_q;
  logic             rx_valid_q, rx_err_q;
  logic [7:0]       rx_data_q;

  logic fall_c, fall_nxt_c, to_run_c, timeout_c;

  always_comb begin
    flip_c = '0;
    for (int i = 0; i < 2; i++)
      flip_c[i] = (sync2_q[i] != filt_q[i]) && (fcnt_q[i] == FLT_W'(FILTER - 1));
  end

  // Synchronizers plus stability filter; a level is accepted after FILTER stable cycles.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      clk_prev_q <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      sync1_q    <= {ps2_data_i, ps2_clk_i};
      sync2_q    <= sync1_q;
      clk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (flip_c[i]) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + FLT_W'(1);
        end
      end
    end
  end

  assign fall_c     = clk_prev_q & ~filt_q[0];
  // A falling edge will be visible next cycle; lets tx_ready drop in time for RX priority.
  assign fall_nxt_c = filt_q[0] & flip_c[0];
  assign to_run_c   = (state_q == S_RX) || (state_q == S_TX) ||
                      (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
  assign timeout_c  = to_run_c && !fall_c && (to_q == TO_W'(TIMEOUT_CYCLES));

  // Inter-edge watchdog, saturating.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                 to_q <= '0;
    else if (!to_run_c || fall_c) to_q <= '0;
    else if (to_q != TO_W'(TIMEOUT_CYCLES)) to_q <= to_q + TO_W'(1);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= S_IDLE;
      bit_q      <= '0;
      rx_sh_q    <= '0;
      start_q    <= 1'b0;
      tx_q       <= '0;
      par_q      <= 1'b0;
      inh_q      <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_ready_q <= 1'b1;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      if (timeout_c) begin
        state_q    <= S_IDLE;
        clk_oe_q   <= 1'b0;
        data_oe_q  <= 1'b0;
        tx_ready_q <= !fall_nxt_c;
        if (state_q == S_RX) rx_err_q <= 1'b1;
        else                 tx_err_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            tx_ready_q <= !fall_nxt_c;
            if (fall_c) begin
              state_q    <= S_RX;
              bit_q      <= 4'd1;
              start_q    <= filt_q[1];
              tx_ready_q <= 1'b0;
            end else if (tx_valid && tx_ready_q) begin
              state_q    <= S_INHIBIT;
              tx_q       <= tx_data;
              par_q      <= ~^tx_data;
              inh_q      <= '0;
              clk_oe_q   <= 1'b1;
              tx_ready_q <= 1'b0;
            end
          end
          S_RX: begin
            if (fall_c) begin
              if (bit_q == 4'd10) begin
                state_q    <= S_IDLE;
                rx_data_q  <= rx_sh_q[7:0];
                rx_valid_q <= 1'b1;
                rx_err_q   <= start_q | ~(^rx_sh_q) | ~filt_q[1];
                tx_ready_q <= !fall_nxt_c;
              end else begin
                rx_sh_q <= {filt_q[1], rx_sh_q[8:1]};
                bit_q   <= bit_q + 4'd1;
              end
            end
          end
          S_INHIBIT: begin
            if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) begin
              state_q   <= S_REQ;
              clk_oe_q  <= 1'b0;
              data_oe_q <= 1'b1;
            end else begin
              inh_q <= inh_q + INH_W'(1);
            end
          end
          S_REQ: begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b1;
            bit_q     <= '0;
            state_q   <= S_TX;
          end
          S_TX: begin
            if (fall_c) begin
              bit_q <= bit_q + 4'd1;
              if (bit_q < 4'd8) begin
                data_oe_q <= ~tx_q[bit_q[2:0]];
              end else if (bit_q == 4'd8) begin
                data_oe_q <= ~par_q;
              end else begin
                data_oe_q <= 1'b0;
                state_q   <= S_ACK;
              end
            end
          end
          S_ACK: begin
            if (fall_c) begin
              if (!filt_q[1]) begin
                state_q <= S_WAIT_IDLE;
              end else begin
                state_q    <= S_IDLE;
                tx_err_q   <= 1'b1;
                tx_ready_q <= !fall_nxt_c;
              end
            end
          end
          S_WAIT_IDLE: begin
            if (filt_q == 2'b11) begin
              state_q    <= S_IDLE;
              tx_done_q  <= 1'b1;
              tx_ready_q <= !fall_nxt_c;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = tx_ready_q;
  assign tx_done     = tx_done_q;
  assign tx_err      = tx_err_q;
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign rx_err      = rx_err_q;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Bench for ps2_host_ctrl: device model on the wired-AND bus, scoreboard queues
// of expected rx/tx events checked against events captured from the DUT.
module tb_ps2_host_ctrl;

  localparam int unsigned FLT = 4;
  localparam int unsigned INH = 200;
  localparam int unsigned TMO = 1500;
  localparam int          HP  = 20;

  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_done, tx_err, rx_valid, rx_err;
  logic [7:0] rx_data;

  int nvec = 0, nerr = 0;
  int cyc = 0;
  int clk_oe_cycles = 0;
  logic [9:0] rx_exp[$], rx_got[$];
  logic [1:0] tx_exp[$], tx_got[$];

  ps2_host_ctrl #(.CLK_HZ(100_000_000), .FILTER(FLT), .INHIBIT_CYCLES(INH),
                  .TIMEOUT_CYCLES(TMO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_err(tx_err),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err)
  );

  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  // Event capture for the scoreboard.
  always @(negedge ACLK) begin
    if (ps2_clk_oe) clk_oe_cycles <= clk_oe_cycles + 1;
    if (rx_valid || rx_err) rx_got.push_back({rx_valid, rx_err, rx_data});
    if (tx_done || tx_err)  tx_got.push_back({tx_done, tx_err});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par,
                                           input logic stop);
    return {stop, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic dev_send(input logic [10:0] f, input int n, output int last_fall);
    last_fall = 0;
    for (int i = 0; i < n; i++) begin
      dev_data = f[i];
      repeat (HP/2) @(negedge ACLK);
      dev_clk = 1'b0;
      last_fall = cyc;
      repeat (HP) @(negedge ACLK);
      dev_clk = 1'b1;
      repeat (HP/2) @(negedge ACLK);
    end
    dev_data = 1'b1;
    repeat (HP) @(negedge ACLK);
  endtask

  // Call at a negedge; holds tx_valid until a cycle with tx_ready high.
  task automatic host_cmd(input logic [7:0] d, output bit ok);
    bit rdy;
    ok = 1'b0;
    tx_valid = 1'b1;
    tx_data  = d;
    for (int i = 0; i < 5000; i++) begin
      rdy = tx_ready;
      @(posedge ACLK);
      if (rdy) begin ok = 1'b1; break; end
      @(negedge ACLK);
    end
    @(negedge ACLK);
    tx_valid = 1'b0;
  endtask

  // Device side of a host transmit: measure inhibit, clock in 10 bits, then ack.
  task automatic dev_host_rx(input logic ack, output logic [9:0] bits, output int inh,
                             output logic req);
    inh = 0;
    bits = '0;
    for (int i = 0; i < 100 && !ps2_clk_oe; i++) @(negedge ACLK);
    while (ps2_clk_oe && inh < 20000) begin
      inh++;
      @(negedge ACLK);
    end
    req = ps2_data_oe;
    repeat (HP) @(negedge ACLK);
    for (int i = 0; i < 10; i++) begin
      dev_clk = 1'b0;
      repeat (HP) @(negedge ACLK);
      bits[i] = ps2_data_i;
      dev_clk = 1'b1;
      repeat (HP) @(negedge ACLK);
    end
    dev_data = ack;
    repeat (HP/2) @(negedge ACLK);
    dev_clk = 1'b0;
    repeat (HP) @(negedge ACLK);
    dev_clk = 1'b1;
    repeat (HP/2) @(negedge ACLK);
    dev_data = 1'b1;
    repeat (HP) @(negedge ACLK);
  endtask

  task automatic test_reset;
    ARESETN = 1'b0;
    repeat (4) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    nvec++; if (ps2_clk_oe !== 1'b0) begin nerr++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
    nvec++; if (ps2_data_oe !== 1'b0) begin nerr++; $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); end
    nvec++; if (tx_ready !== 1'b1) begin nerr++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    nvec++; if (rx_data !== 8'h00) begin nerr++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    nvec++;
    if ({rx_valid, rx_err, tx_done, tx_err} !== 4'b0000) begin
      nerr++; $display("FAIL reset_pulses: got %b want 0000", {rx_valid, rx_err, tx_done, tx_err});
    end
  endtask

  task automatic rx_frame(input string name, input logic [7:0] d, input logic bad_par,
                          input logic stop, input logic exp_err);
    int lf;
    logic [9:0] g, e;
    rx_exp.push_back({1'b1, exp_err, d});
    dev_send(mk_frame(d, bad_par, stop), 11, lf);
    for (int i = 0; i < 200 && rx_got.size() == 0; i++) @(negedge ACLK);
    nvec++;
    if (rx_got.size() == 0) begin
      nerr++; $display("FAIL %s_wait: no rx event within bound", name);
      void'(rx_exp.pop_front());
    end else begin
      g = rx_got.pop_front();
      e = rx_exp.pop_front();
      nvec++;
      if (g !== e) begin nerr++; $display("FAIL %s: got valid/err/data %b/%b/%h want %b/%b/%h", name, g[9], g[8], g[7:0], e[9], e[8], e[7:0]); end
    end
    repeat (40) @(negedge ACLK);
    nvec++;
    if (rx_got.size() != 0) begin nerr++; $display("FAIL %s_extra: got %0d extra rx events want 0", name, rx_got.size()); rx_got.delete(); end
  endtask

  task automatic test_rx_good;
    rx_frame("rx_1c", 8'h1C, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_rx_errors;
    rx_frame("rx_bad_parity", 8'h1C, 1'b1, 1'b1, 1'b1);
    rx_frame("rx_bad_stop", 8'h1C, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic tx_cmd(input string name, input logic [7:0] d, input logic ack);
    bit ok;
    logic [9:0] bits, eb;
    logic [1:0] g, e;
    int inh;
    logic req;
    tx_exp.push_back(ack ? 2'b01 : 2'b10);
    eb = {1'b1, ~^d, d};
    host_cmd(d, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL %s_accept: got no handshake want accept", name); end
    dev_host_rx(ack, bits, inh, req);
    nvec++; if (inh != int'(INH)) begin nerr++; $display("FAIL %s_inhibit: got %0d cycles want %0d", name, inh, INH); end
    nvec++; if (req !== 1'b1) begin nerr++; $display("FAIL %s_req: got data_oe %b at clock release want 1", name, req); end
    nvec++; if (bits !== eb) begin nerr++; $display("FAIL %s_bits: got %b want %b", name, bits, eb); end
    for (int i = 0; i < 200 && tx_got.size() == 0; i++) @(negedge ACLK);
    nvec++;
    if (tx_got.size() == 0) begin
      nerr++; $display("FAIL %s_wait: no tx event within bound", name);
      void'(tx_exp.pop_front());
    end else begin
      g = tx_got.pop_front();
      e = tx_exp.pop_front();
      nvec++;
      if (g !== e) begin nerr++; $display("FAIL %s_result: got done/err %b want %b", name, g, e); end
    end
    repeat (100) @(negedge ACLK);
    nvec++; if (tx_got.size() != 0) begin nerr++; $display("FAIL %s_extra: got %0d extra tx events want 0", name, tx_got.size()); tx_got.delete(); end
    nvec++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin nerr++; $display("FAIL %s_release: got oe %b want 00", name, {ps2_clk_oe, ps2_data_oe}); end
    nvec++; if (tx_ready !== 1'b1) begin nerr++; $display("FAIL %s_ready: got %b want 1", name, tx_ready); end
  endtask

  task automatic test_tx_ack;
    tx_cmd("tx_ed_ack", 8'hED, 1'b0);
  endtask

  task automatic test_tx_noack;
    tx_cmd("tx_ed_noack", 8'hED, 1'b1);
  endtask

  task automatic test_rx_timeout;
    int lf, dly;
    logic [9:0] g;
    dev_send(mk_frame(8'h33, 1'b0, 1'b1), 5, lf);
    for (int i = 0; i < int'(TMO) + 500 && rx_got.size() == 0; i++) @(negedge ACLK);
    dly = cyc - lf;
    nvec++;
    if (rx_got.size() == 0) begin
      nerr++; $display("FAIL rx_timeout_wait: no rx_err within bound");
    end else begin
      g = rx_got.pop_front();
      nvec++; if (g[9:8] !== 2'b01) begin nerr++; $display("FAIL rx_timeout_flags: got valid/err %b want 01", g[9:8]); end
      nvec++;
      if (dly < int'(TMO) || dly > int'(TMO) + 30) begin
        nerr++; $display("FAIL rx_timeout_delay: got %0d cycles want %0d..%0d", dly, TMO, TMO + 30);
      end
    end
    rx_frame("rx_after_timeout", 8'h5A, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    int lf, o0, inh;
    bit ok;
    logic req;
    logic [9:0] bits, g, e;
    logic [1:0] tg;
    rx_exp.push_back({2'b10, 8'hA7});
    o0 = clk_oe_cycles;
    fork
      dev_send(mk_frame(8'hA7, 1'b0, 1'b1), 11, lf);
      begin
        for (int i = 0; i < 100 && tx_ready; i++) @(negedge ACLK);
        host_cmd(8'h3C, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL b2b_accept: got no handshake want accept"); end
        nvec++; if (rx_got.size() != 1) begin nerr++; $display("FAIL b2b_order: got %0d rx events before accept want 1", rx_got.size()); end
        nvec++; if (clk_oe_cycles != o0) begin nerr++; $display("FAIL b2b_inhibit_during_rx: got %0d oe cycles want 0", clk_oe_cycles - o0); end
      end
    join
    nvec++;
    if (rx_got.size() == 0) begin
      nerr++; $display("FAIL b2b_rx_wait: no rx event");
      void'(rx_exp.pop_front());
    end else begin
      g = rx_got.pop_front();
      e = rx_exp.pop_front();
      nvec++; if (g !== e) begin nerr++; $display("FAIL b2b_rx: got %b/%b/%h want %b/%b/%h", g[9], g[8], g[7:0], e[9], e[8], e[7:0]); end
    end
    dev_host_rx(1'b0, bits, inh, req);
    nvec++; if (bits !== {1'b1, ~^8'h3C, 8'h3C}) begin nerr++; $display("FAIL b2b_tx_bits: got %b want %b", bits, {1'b1, ~^8'h3C, 8'h3C}); end
    for (int i = 0; i < 200 && tx_got.size() == 0; i++) @(negedge ACLK);
    nvec++;
    if (tx_got.size() == 0) begin
      nerr++; $display("FAIL b2b_tx_wait: no tx event");
    end else begin
      tg = tx_got.pop_front();
      nvec++; if (tg !== 2'b10) begin nerr++; $display("FAIL b2b_tx_result: got done/err %b want 10", tg); end
    end
  endtask

  task automatic test_reset_inhibit;
    bit ok;
    int o0;
    host_cmd(8'h55, ok);
    repeat (50) @(negedge ACLK);
    nvec++; if (ps2_clk_oe !== 1'b1) begin nerr++; $display("FAIL rst_inh_active: got clk_oe %b want 1", ps2_clk_oe); end
    #2 ARESETN = 1'b0;
    #1;
    nvec++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin nerr++; $display("FAIL rst_inh_async: got oe %b want 00", {ps2_clk_oe, ps2_data_oe}); end
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    o0 = clk_oe_cycles;
    repeat (300) @(negedge ACLK);
    nvec++; if (clk_oe_cycles != o0) begin nerr++; $display("FAIL rst_inh_resumed: got %0d oe cycles want 0", clk_oe_cycles - o0); end
    nvec++; if (rx_got.size() + tx_got.size() != 0) begin nerr++; $display("FAIL rst_inh_pulses: got %0d events want 0", rx_got.size() + tx_got.size()); end
    nvec++; if (tx_ready !== 1'b1) begin nerr++; $display("FAIL rst_inh_ready: got %b want 1", tx_ready); end
  endtask

  initial begin
    test_reset();
    test_rx_good();
    test_rx_errors();
    test_tx_ack();
    test_tx_noack();
    test_rx_timeout();
    test_back_to_back();
    test_reset_inhibit();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ps2_host_ctrl.md
# ps2_host_ctrl

PS/2 host-side line controller that owns the bidirectional two-wire PS/2 bus and sequences it between device-to-host reception and host-to-device command transmission. It sits between the open-drain PS/2 pads and the AXI4-Lite register slave of the PS/2 peripheral. It arbitrates the shared bus, frames and checks every byte, and reports bytes and errors through simple valid/ready strobes.

## Interface
- CLK_HZ, 100_000_000: ACLK frequency; documentation only.
- FILTER, 8: ACLK cycles a synchronized ps2 clock level must be stable before an edge is accepted.
- INHIBIT_CYCLES, 10000: clock-inhibit duration before a host transmit (100 us at 100 MHz).
- TIMEOUT_CYCLES, 200000: maximum ACLK cycles between accepted falling edges inside a frame (2 ms).

- ACLK  in  1  system clock.
- ARESETN  in  1  asynchronous, active-low reset.
- ps2_clk_i  in  1  PS/2 clock pad input (asynchronous).
- ps2_data_i  in  1  PS/2 data pad input (asynchronous).
- ps2_clk_oe  out  1  1 = drive clock pad low; 0 = release.
- ps2_data_oe  out  1  1 = drive data pad low; 0 = release.
- tx_valid  in  1  command byte request.
- tx_data  in  8  command byte.
- tx_ready  out  1  controller accepts tx_data this cycle.
- tx_done  out  1  one-cycle pulse: command sent and acknowledged.
- tx_err  out  1  one-cycle pulse: missing ack or timeout during transmit.
- rx_valid  out  1  one-cycle pulse: rx_data holds a received frame.
- rx_data  out  8  last received byte; held until next rx_valid.
- rx_err  out  1  one-cycle pulse with rx_valid on bad frame, or alone on receive timeout.

## Operation
- Inputs pass through 2-flop synchronizers, then a FILTER-cycle stability filter; "falling edge" means filtered clock 1 -> 0.
- States: IDLE, RX, INHIBIT, REQ, TX, ACK, WAIT_IDLE.
- IDLE: tx_ready = 1. A falling edge -> RX with bit count 1 (start bit sampled). Otherwise tx_valid -> latch tx_data, compute odd parity, go INHIBIT.
- Simultaneous falling edge and tx_valid in IDLE: RX wins, tx_ready = 0 that cycle, request stays pending.
- RX: sample filtered data on each falling edge, 11 bits: start(0), D0..D7 LSB first, odd parity, stop(1). After the 11th edge: rx_data <= D7..D0, rx_valid pulse; rx_err also pulses if start != 0, parity even, or stop != 1. rx_data updates even on error. Return to IDLE.
- INHIBIT: ps2_clk_oe = 1 for exactly INHIBIT_CYCLES, then REQ.
- REQ: ps2_data_oe = 1 (start bit), ps2_clk_oe = 0; go TX.
- TX: on falling edges 1..8 put D0..D7, edge 9 parity, edge 10 release data (stop). Data bit 0 -> oe = 1, bit 1 -> oe = 0. Then ACK.
- ACK: on the 11th falling edge sample data. 0 -> WAIT_IDLE. 1 -> tx_err pulse, IDLE.
- WAIT_IDLE: wait for filtered clock and data both high, then tx_done pulse and IDLE.
- Timeout: an idle counter resets on each accepted falling edge. Reaching TIMEOUT_CYCLES in RX, TX, ACK or WAIT_IDLE releases both oe and returns to IDLE. It pulses rx_err (from RX) or tx_err (otherwise).
- Both oe outputs are 0 in every state other than those stated above.

## Timing
- Reset (asynchronous): state IDLE; ps2_clk_oe = ps2_data_oe = 0 immediately; tx_ready = 1 from the first cycle after release; all pulses 0; rx_data = 0x00.
- Reset mid-frame aborts silently: no err or done pulse, bus released in the same cycle.
- Pin-to-edge latency: 2 + FILTER cycles. rx_valid is registered one cycle after the 11th accepted edge.
- tx handshake: transfer occurs on a cycle with tx_valid && tx_ready. tx_ready deasserts the next cycle and stays low until return to IDLE.
- ps2_clk_oe rises the cycle after acceptance. ps2_data_oe rises exactly INHIBIT_CYCLES later, in the same cycle ps2_clk_oe falls.
- TX data changes one cycle after each accepted falling edge.
- Counters are sized from the parameters (clog2) and saturate; they never wrap.

## Test plan
- Device sends 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12 kHz -> single rx_valid, rx_data = 0x1C, rx_err = 0.
- Same frame with parity 1 -> rx_valid with rx_err = 1, rx_data = 0x1C. Then frame with stop 0 -> rx_err = 1.
- Host sends 0xED, device model clocks and acks -> clock driven low exactly 10000 cycles, data bits 1,0,1,1,0,1,1,1 then parity 1, stop released, tx_done pulse once, tx_ready returns high.
- 0xED with device leaving data high at ack -> tx_err pulse, no tx_done, both oe = 0.
- Device stops after 5 clock edges -> rx_err pulse 200000 cycles after the 5th edge, state IDLE, next full frame received correctly.
- tx_valid asserted the same cycle as a device start edge -> frame received first, then command transmitted. ARESETN pulsed low during INHIBIT -> ps2_clk_oe drops asynchronously and no pulses are emitted.
